eth_tx_scheduler: RTL and testbench

Round-robin transmit scheduler that shares the single Ethernet sender packet buffer among `num_req_p` requesters. It grants one requester exclusive write access, muxes its buffer writes through, and on commit issues the packet-size load and send strobes to the sender. It then holds off the next grant until the sender returns ready. It sits between requester logic and the TX side of the MAC-with-buffer block, in the `clk_i` domain.

---
 rtl/eth_tx_scheduler_pkg.sv | 21 ++
 rtl/eth_tx_scheduler_if.sv | 48 ++++
 rtl/eth_tx_scheduler_rr_arbiter.sv | 31 +++
 rtl/eth_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_tx_scheduler_pkg.sv
// eth_tx_scheduler shared types and constants.
// FSM state encoding and drop counter helpers.
package eth_tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_SEND,
    S_DRAIN
  } eth_tx_sched_state_e;

  localparam int DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Requester and sender side signals of the TX scheduler.
// master: scheduler view, slave: requesters plus sender view.
interface eth_tx_scheduler_if #(
  parameter int num_req_p            = 4,
  parameter int addr_width_lp        = 11,
  parameter int axis_width_p         = 64,
  parameter int packet_size_width_lp = 12
);

  logic [num_req_p-1:0]                      req_v_i;
  logic [num_req_p-1:0]                      grant_o;
  logic [num_req_p*addr_width_lp-1:0]        wr_addr_i;
  logic [num_req_p*2-1:0]                    wr_op_size_i;
  logic [num_req_p*axis_width_p-1:0]         wr_data_i;
  logic [num_req_p-1:0]                      wr_v_i;
  logic [num_req_p-1:0]                      commit_v_i;
  logic [num_req_p*packet_size_width_lp-1:0] commit_size_i;
  logic [num_req_p-1:0]                      sent_o;
  logic [num_req_p-1:0]                      error_o;

  logic [addr_width_lp-1:0]        buffer_write_addr_o;
  logic [1:0]                      buffer_write_op_size_o;
  logic [axis_width_p-1:0]         buffer_write_data_o;
  logic                            buffer_write_v_o;
  logic                            tx_packet_size_v_o;
  logic [packet_size_width_lp-1:0] tx_packet_size_o;
  logic                            send_o;
  logic                            tx_ready_i;

  modport master (
    input  req_v_i, wr_addr_i, wr_op_size_i, wr_data_i,
    input  wr_v_i, commit_v_i, commit_size_i, tx_ready_i,
    output grant_o, sent_o, error_o,
    output buffer_write_addr_o, buffer_write_op_size_o,
    output buffer_write_data_o, buffer_write_v_o,
    output tx_packet_size_v_o, tx_packet_size_o, send_o
  );

  modport slave (
    output req_v_i, wr_addr_i, wr_op_size_i, wr_data_i,
    output wr_v_i, commit_v_i, commit_size_i, tx_ready_i,
    input  grant_o, sent_o, error_o,
    input  buffer_write_addr_o, buffer_write_op_size_o,
    input  buffer_write_data_o, buffer_write_v_o,
    input  tx_packet_size_v_o, tx_packet_size_o, send_o
  );

endinterface

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// Search starts at i_ptr and wraps at num_req_p-1.
module eth_rr_arbiter #(
  parameter  int num_req_p = 4,
  localparam int idx_w_lp  = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] i_req,
  input  logic [idx_w_lp-1:0]  i_ptr,
  output logic [num_req_p-1:0] o_grant,
  output logic [idx_w_lp-1:0]  o_idx,
  output logic                 o_v
);

  logic [idx_w_lp-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_v     = 1'b0;
    w_j     = '0;
    for (int i = 0; i < num_req_p; i++) begin
      w_j = idx_w_lp'((int'(i_ptr) + i) % num_req_p);
      if (!o_v && i_req[w_j]) begin
        o_v         = 1'b1;
        o_idx       = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Round-robin owner of the shared Ethernet TX packet buffer.
// Grants one requester, muxes its writes, then loads size and sends.
module eth_tx_scheduler
  import eth_tx_sched_pkg::*;
#(
  parameter  int num_req_p            = 4,
  parameter  int buf_size_p           = 2048,
  parameter  int axis_width_p         = 64,
  parameter  int timeout_p            = 4096,
  localparam int addr_width_lp        = $clog2(buf_size_p),
  localparam int packet_size_width_lp = $clog2(buf_size_p) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  eth_tx_scheduler_if.master bus,
  output logic [DROP_W-1:0] drop_count_o
);

  localparam int idx_w_lp   = $clog2(num_req_p);
  localparam int timer_w_lp = $clog2(timeout_p);
  localparam int aw_lp      = addr_width_lp;
  localparam int dw_lp      = axis_width_p;
  localparam int pw_lp      = packet_size_width_lp;

  localparam logic [timer_w_lp-1:0] timer_max_lp =
    timer_w_lp'(timeout_p - 1);
  localparam logic [pw_lp-1:0] size_max_lp = pw_lp'(buf_size_p);
  localparam logic [idx_w_lp-1:0] idx_last_lp =
    idx_w_lp'(num_req_p - 1);

  eth_tx_sched_state_e     r_state;
  logic [idx_w_lp-1:0]     r_ptr;
  logic [idx_w_lp-1:0]     r_owner;
  logic [num_req_p-1:0]    r_grant;
  logic [timer_w_lp-1:0]   r_timer;
  logic [pw_lp-1:0]        r_size;
  logic                    r_size_v;
  logic [num_req_p-1:0]    r_error;
  logic [DROP_W-1:0]       r_drop;

  logic [num_req_p-1:0]    w_arb_grant;
  logic [idx_w_lp-1:0]     w_arb_idx;
  logic                    w_arb_v;
  logic                    w_own_req;
  logic                    w_own_commit;
  logic [pw_lp-1:0]        w_own_size;
  logic                    w_size_ok;
  logic                    w_send;
  logic [num_req_p-1:0]    w_own_oh;

  eth_rr_arbiter #(
    .num_req_p (num_req_p)
  ) u_arb (
    .i_req   (bus.req_v_i),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_v     (w_arb_v)
  );

  assign w_own_req    = bus.req_v_i[r_owner];
  assign w_own_commit = bus.commit_v_i[r_owner];
  assign w_own_size   = bus.commit_size_i[r_owner*pw_lp +: pw_lp];
  assign w_size_ok    = (w_own_size != '0) && (w_own_size <= size_max_lp);
  assign w_own_oh     = num_req_p'(1) << r_owner;

  // Write mux keys off the registered grant, so nothing moves while idle.
  assign bus.buffer_write_addr_o    = bus.wr_addr_i[r_owner*aw_lp +: aw_lp];
  assign bus.buffer_write_op_size_o = bus.wr_op_size_i[r_owner*2 +: 2];
  assign bus.buffer_write_data_o    = bus.wr_data_i[r_owner*dw_lp +: dw_lp];
  assign bus.buffer_write_v_o       = |(r_grant & bus.wr_v_i);

  assign w_send = (r_state == S_SEND) & bus.tx_ready_i & ~reset_i;

  assign bus.grant_o            = r_grant;
  assign bus.error_o            = r_error;
  assign bus.send_o             = w_send;
  assign bus.sent_o             = {num_req_p{w_send}} & w_own_oh;
  assign bus.tx_packet_size_v_o = r_size_v;
  assign bus.tx_packet_size_o   = r_size;
  assign drop_count_o           = r_drop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_timer  <= '0;
      r_size   <= '0;
      r_size_v <= 1'b0;
      r_error  <= '0;
      r_drop   <= '0;
    end else begin
      r_size_v <= 1'b0;
      r_error  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.tx_ready_i && w_arb_v) begin
            r_grant <= w_arb_grant;
            r_owner <= w_arb_idx;
            r_timer <= '0;
            r_ptr   <= (w_arb_idx == idx_last_lp) ? '0 : w_arb_idx + 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Commit beats a same-cycle deassert or timeout.
          if (w_own_commit) begin
            r_grant <= '0;
            if (w_size_ok) begin
              r_size   <= w_own_size;
              r_size_v <= 1'b1;
              r_state  <= S_LOAD;
            end else begin
              r_error <= r_grant;
              r_drop  <= sat_inc(r_drop);
              r_state <= S_IDLE;
            end
          end else if (!w_own_req) begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (r_timer == timer_max_lp) begin
            r_grant <= '0;
            r_error <= r_grant;
            r_drop  <= sat_inc(r_drop);
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_LOAD: r_state <= S_SEND;
        S_SEND: if (bus.tx_ready_i) r_state <= S_DRAIN;
        S_DRAIN: if (bus.tx_ready_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler.
// Scenario tasks with inline hand-computed checks.
module tb_eth_tx_scheduler;

  localparam int NR = 4;
  localparam int AW = 11;
  localparam int DW = 64;
  localparam int PW = 12;

  logic        clk;
  logic        rst;
  logic [15:0] drop;
  int          checks;
  int          errors;

  eth_tx_scheduler_if #(
    .num_req_p            (NR),
    .addr_width_lp        (AW),
    .axis_width_p         (DW),
    .packet_size_width_lp (PW)
  ) bus ();

  eth_tx_scheduler #(
    .num_req_p    (NR),
    .buf_size_p   (2048),
    .axis_width_p (DW),
    .timeout_p    (4096)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .bus          (bus),
    .drop_count_o (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_v_i       = '0;
    bus.wr_addr_i     = '0;
    bus.wr_op_size_i  = '0;
    bus.wr_data_i     = '0;
    bus.wr_v_i        = '0;
    bus.commit_v_i    = '0;
    bus.commit_size_i = '0;
    bus.tx_ready_i    = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_size(input int r, input int sz);
    bus.commit_size_i[r*PW +: PW] = PW'(sz);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.grant_o !== 4'b0000) begin
      $display("FAIL reset_grant got %b want 0000", bus.grant_o);
      errors++;
    end
    checks++;
    if ({bus.send_o, bus.tx_packet_size_v_o, bus.buffer_write_v_o}
        !== 3'b000) begin
      $display("FAIL reset_strobes got %b want 000",
        {bus.send_o, bus.tx_packet_size_v_o, bus.buffer_write_v_o});
      errors++;
    end
    checks++;
    if ({bus.sent_o, bus.error_o} !== 8'h00) begin
      $display("FAIL reset_pulses got %h want 00",
        {bus.sent_o, bus.error_o});
      errors++;
    end
    checks++;
    if (drop !== 16'd0 || bus.tx_packet_size_o !== 12'd0) begin
      $display("FAIL reset_count_size got %0d/%0d want 0/0",
        drop, bus.tx_packet_size_o);
      errors++;
    end
  endtask

  task automatic test_single();
    logic [63:0] d;
    int bad;
    bus.req_v_i = 4'b0010;
    tick();
    checks++;
    if (bus.grant_o !== 4'b0010) begin
      $display("FAIL single_grant got %b want 0010", bus.grant_o);
      errors++;
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      d = 64'hA5A5_0000_0000_0000 | 64'(k * 3 + 1);
      bus.wr_addr_i[1*AW +: AW]  = AW'(k * 8);
      bus.wr_data_i[1*DW +: DW]  = d;
      bus.wr_op_size_i[1*2 +: 2] = 2'b11;
      bus.wr_v_i = 4'b0010;
      #1;
      if (bus.buffer_write_v_o !== 1'b1 ||
          bus.buffer_write_addr_o !== AW'(k * 8) ||
          bus.buffer_write_data_o !== d ||
          bus.buffer_write_op_size_o !== 2'b11) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL single_writes got %0d bad beats want 0", bad);
      errors++;
    end
    bus.wr_v_i = '0;
    bus.commit_v_i = 4'b0010;
    set_size(1, 64);
    tick();
    bus.commit_v_i = '0;
    bus.req_v_i = '0;
    checks++;
    if (bus.tx_packet_size_v_o !== 1'b1 || bus.tx_packet_size_o !== 12'd64
        || bus.grant_o !== 4'b0000 || bus.send_o !== 1'b0) begin
      $display("FAIL single_load got v%b sz%0d g%b s%b want v1 sz64 g0000 s0",
        bus.tx_packet_size_v_o, bus.tx_packet_size_o, bus.grant_o,
        bus.send_o);
      errors++;
    end
    tick();
    checks++;
    if (bus.send_o !== 1'b1 || bus.sent_o !== 4'b0010 ||
        bus.tx_packet_size_v_o !== 1'b0) begin
      $display("FAIL single_send got s%b sent%b v%b want s1 sent0010 v0",
        bus.send_o, bus.sent_o, bus.tx_packet_size_v_o);
      errors++;
    end
    tick();
    checks++;
    if (bus.send_o !== 1'b0 || bus.sent_o !== 4'b0000) begin
      $display("FAIL single_drain got s%b sent%b want s0 sent0000",
        bus.send_o, bus.sent_o);
      errors++;
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [3:0] last_oh;
    int n_sent;
    int n_bad;
    int cnt;
    do_reset();
    n_sent = 0;
    n_bad = 0;
    last_oh = '0;
    bus.req_v_i = 4'b1111;
    for (int r = 0; r < NR; r++) set_size(r, 8);
    for (int p = 0; p < 5; p++) begin
      cnt = 0;
      while (bus.grant_o == 4'b0000 && cnt < 20) begin
        tick();
        if (bus.sent_o != 0) begin
          if (bus.sent_o === last_oh) n_sent++;
          else n_bad++;
        end
        cnt++;
      end
      checks++;
      if (bus.grant_o !== 4'(1 << exp_idx[p])) begin
        $display("FAIL rr_order_%0d got %b want idx %0d",
          p, bus.grant_o, exp_idx[p]);
        errors++;
      end
      last_oh = bus.grant_o;
      bus.commit_v_i = bus.grant_o;
      tick();
      bus.commit_v_i = '0;
    end
    bus.req_v_i = '0;
    for (int k = 0; k < 6; k++) begin
      if (bus.sent_o != 0) begin
        if (bus.sent_o === last_oh) n_sent++;
        else n_bad++;
      end
      tick();
    end
    checks++;
    if (n_sent != 5 || n_bad != 0) begin
      $display("FAIL rr_sent got %0d good %0d bad want 5 good 0 bad",
        n_sent, n_bad);
      errors++;
    end
  endtask

  task automatic test_bad_size();
    int n_send;
    do_reset();
    n_send = 0;
    bus.req_v_i = 4'b0100;
    tick();
    checks++;
    if (bus.grant_o !== 4'b0100) begin
      $display("FAIL bad_grant got %b want 0100", bus.grant_o);
      errors++;
    end
    bus.commit_v_i = 4'b0100;
    set_size(2, 0);
    tick();
    bus.commit_v_i = '0;
    if (bus.send_o) n_send++;
    checks++;
    if (bus.error_o !== 4'b0100 || drop !== 16'd1 ||
        bus.grant_o !== 4'b0000) begin
      $display("FAIL bad_size0 got e%b d%0d g%b want e0100 d1 g0000",
        bus.error_o, drop, bus.grant_o);
      errors++;
    end
    tick();
    if (bus.send_o) n_send++;
    checks++;
    if (bus.grant_o !== 4'b0100 || bus.error_o !== 4'b0000) begin
      $display("FAIL bad_regrant got g%b e%b want g0100 e0000",
        bus.grant_o, bus.error_o);
      errors++;
    end
    bus.commit_v_i = 4'b0100;
    set_size(2, 2049);
    tick();
    bus.commit_v_i = '0;
    if (bus.send_o) n_send++;
    checks++;
    if (bus.error_o !== 4'b0100 || drop !== 16'd2) begin
      $display("FAIL bad_size2049 got e%b d%0d want e0100 d2",
        bus.error_o, drop);
      errors++;
    end
    tick();
    if (bus.send_o) n_send++;
    bus.commit_v_i = 4'b0100;
    set_size(2, 2048);
    tick();
    bus.commit_v_i = '0;
    bus.req_v_i = '0;
    checks++;
    if (bus.tx_packet_size_v_o !== 1'b1 || bus.tx_packet_size_o !== 12'd2048
        || bus.error_o !== 4'b0000 || drop !== 16'd2) begin
      $display("FAIL bad_size2048 got v%b sz%0d e%b d%0d want v1 sz2048 e0 d2",
        bus.tx_packet_size_v_o, bus.tx_packet_size_o, bus.error_o, drop);
      errors++;
    end
    checks++;
    if (n_send != 0) begin
      $display("FAIL bad_nosend got %0d sends want 0", n_send);
      errors++;
    end
    repeat (4) tick();
  endtask

  task automatic test_timeout();
    int held;
    int n;
    do_reset();
    bus.req_v_i = 4'b0011;
    tick();
    held = 0;
    n = 0;
    while (bus.error_o == 4'b0000 && n < 5000) begin
      if (bus.grant_o === 4'b0001) held++;
      tick();
      n++;
    end
    checks++;
    if (held != 4096) begin
      $display("FAIL timeout_held got %0d cycles want 4096", held);
      errors++;
    end
    checks++;
    if (bus.error_o !== 4'b0001 || bus.grant_o !== 4'b0000 ||
        drop !== 16'd1) begin
      $display("FAIL timeout_err got e%b g%b d%0d want e0001 g0000 d1",
        bus.error_o, bus.grant_o, drop);
      errors++;
    end
    tick();
    checks++;
    if (bus.grant_o !== 4'b0010) begin
      $display("FAIL timeout_next got %b want 0010", bus.grant_o);
      errors++;
    end
    bus.req_v_i = '0;
    tick();
  endtask

  task automatic test_nonowner();
    do_reset();
    bus.req_v_i = 4'b1000;
    tick();
    bus.wr_data_i[0*DW +: DW] = 64'h1111_1111_1111_1111;
    bus.wr_data_i[3*DW +: DW] = 64'h3333_0000_DEAD_BEEF;
    bus.wr_addr_i[3*AW +: AW] = 11'd1000;
    bus.wr_v_i = 4'b0111;
    #1;
    checks++;
    if (bus.buffer_write_v_o !== 1'b0) begin
      $display("FAIL nonowner_ignored got %b want 0", bus.buffer_write_v_o);
      errors++;
    end
    bus.wr_v_i = 4'b1001;
    #1;
    checks++;
    if (bus.buffer_write_v_o !== 1'b1 ||
        bus.buffer_write_data_o !== 64'h3333_0000_DEAD_BEEF ||
        bus.buffer_write_addr_o !== 11'd1000) begin
      $display("FAIL owner_write got v%b d%h a%0d want v1 d3333...beef a1000",
        bus.buffer_write_v_o, bus.buffer_write_data_o,
        bus.buffer_write_addr_o);
      errors++;
    end
    bus.req_v_i = '0;
    bus.wr_v_i = 4'b1111;
    tick();
    checks++;
    if (bus.grant_o !== 4'b0000 || bus.buffer_write_v_o !== 1'b0 ||
        bus.error_o !== 4'b0000) begin
      $display("FAIL abandon got g%b v%b e%b want g0000 v0 e0000",
        bus.grant_o, bus.buffer_write_v_o, bus.error_o);
      errors++;
    end
    bus.wr_v_i = '0;
    tick();
  endtask

  task automatic test_stall_and_reset();
    int n_send;
    do_reset();
    n_send = 0;
    bus.req_v_i = 4'b0001;
    tick();
    bus.commit_v_i = 4'b0001;
    set_size(0, 100);
    tick();
    bus.commit_v_i = '0;
    bus.req_v_i = '0;
    bus.tx_ready_i = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.send_o !== 1'b0) n_send++;
    end
    checks++;
    if (n_send != 0) begin
      $display("FAIL stall_nosend got %0d sends want 0", n_send);
      errors++;
    end
    bus.tx_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.send_o !== 1'b1 || bus.sent_o !== 4'b0001) begin
      $display("FAIL stall_release got s%b sent%b want s1 sent0001",
        bus.send_o, bus.sent_o);
      errors++;
    end
    tick();
    tick();
    bus.req_v_i = 4'b0010;
    tick();
    checks++;
    if (bus.grant_o !== 4'b0010) begin
      $display("FAIL rst_pre_grant got %b want 0010", bus.grant_o);
      errors++;
    end
    bus.commit_v_i = 4'b0010;
    set_size(1, 50);
    bus.wr_v_i = 4'b0010;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.grant_o !== 4'b0000 || bus.tx_packet_size_v_o !== 1'b0 ||
        bus.tx_packet_size_o !== 12'd0 || bus.buffer_write_v_o !== 1'b0 ||
        bus.send_o !== 1'b0 || bus.sent_o !== 4'b0000 ||
        bus.error_o !== 4'b0000 || drop !== 16'd0) begin
      $display("FAIL rst_mid got g%b v%b sz%0d bw%b s%b sent%b e%b d%0d want zeros",
        bus.grant_o, bus.tx_packet_size_v_o, bus.tx_packet_size_o,
        bus.buffer_write_v_o, bus.send_o, bus.sent_o, bus.error_o, drop);
      errors++;
    end
    rst = 1'b0;
    clear_inputs();
    n_send = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.send_o !== 1'b0 || bus.sent_o !== 4'b0000) n_send++;
    end
    checks++;
    if (n_send != 0) begin
      $display("FAIL rst_nosend got %0d sends want 0", n_send);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_bad_size();
    test_timeout();
    test_nonowner();
    test_stall_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
